// File: rtl/llr_channel_loader_pkg.sv
// Shared LDPC definitions: LLR number format, QBER code range and the
// loader state encoding.
package llr_channel_loader_pkg;

  localparam int LLR_W      = 15;  // Q5.10 two's complement
  localparam int LLR_FRAC   = 10;
  localparam int QBER_MAX   = 10;  // codes 0..10 map to QBER 0.01..0.11
  localparam int QBER_SEL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/llr_channel_loader_lut.sv
// Channel-LLR table L(Pi) = (1-2*xi) * ln((1-p)/p) in Q5.10, indexed by the
// QBER code. Purely combinational; the consumer registers the result.
module Lookup_table_eq6
  import llr_channel_loader_pkg::*;
(
  input  logic                  xi,
  input  logic [QBER_SEL_W-1:0] qber_sel,
  output logic [LLR_W-1:0]      L_Pi,
  output logic                  sign
);

  logic [LLR_W-1:0] mag;

  // Magnitude per QBER code; illegal codes yield zero confidence.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    mag = '0;
    case (qber_sel)
      4'd0:    mag = 15'h1261;
      4'd1:    mag = 15'h0F91;
      4'd2:    mag = 15'h0DE8;
      4'd3:    mag = 15'h0CB6;
      4'd4:    mag = 15'h0BC7;
      4'd5:    mag = 15'h0B02;
      4'd6:    mag = 15'h0A59;
      4'd7:    mag = 15'h09C5;
      4'd8:    mag = 15'h0941;
      4'd9:    mag = 15'h08CA;
      4'd10:   mag = 15'h085D;
      default: mag = '0;
    endcase
  end

  // A 1 bit flips the sign: 15-bit two's-complement negation.
  assign L_Pi = xi ? ((~mag) + LLR_W'(1)) : mag;
  assign sign = xi;

endmodule

// File: rtl/llr_channel_loader.sv
// Streams one sifted-key frame into the decoder's variable-node LLR memory:
// each accepted bit becomes a registered write of its channel LLR and hard
// decision at the bit's index, with done on the final write.
module llr_channel_loader #(
  parameter int N_BITS   = 1024,
  parameter int ADDR_W   = 10,
  parameter int LLR_W    = llr_channel_loader_pkg::LLR_W,
  parameter int QBER_MAX = llr_channel_loader_pkg::QBER_MAX
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [llr_channel_loader_pkg::QBER_SEL_W-1:0] qber_sel,
  input  logic                                      abort,
  input  logic                                      s_valid,
  input  logic                                      s_bit,
  output logic                                      s_ready,
  output logic                                      llr_we,
  output logic [ADDR_W-1:0]                         llr_addr,
  output logic [LLR_W-1:0]                          llr_data,
  output logic                                      llr_hard,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      cfg_err,
  output logic [ADDR_W:0]                           ones_cnt
);

  import llr_channel_loader_pkg::*;

  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BITS - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;       // bits accepted so far; never wraps
  logic [QBER_SEL_W-1:0] qber_q, qber_d;

  logic                  s_ready_d, llr_we_d, llr_hard_d, busy_d, done_d, cfg_err_d;
  logic [ADDR_W-1:0]     llr_addr_d;
  logic [LLR_W-1:0]      llr_data_d;
  logic [ADDR_W:0]       ones_cnt_d;

  logic [LLR_W-1:0]      lut_llr;
  logic                  lut_sign;
  logic                  accept;

  // Single table instance, driven by the live bit and the frame's latched QBER.
  Lookup_table_eq6 u_lut (
    .xi       (s_bit),
    .qber_sel (qber_q),
    .L_Pi     (lut_llr),
    .sign     (lut_sign)
  );

  // abort blocks acceptance so a bit offered with it is never written.
  assign accept = (state_q == LOAD) && s_valid && s_ready && !abort;

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    qber_d     = qber_q;
    s_ready_d  = s_ready;
    busy_d     = busy;
    llr_we_d   = 1'b0;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    llr_addr_d = llr_addr;
    llr_data_d = llr_data;
    llr_hard_d = llr_hard;
    ones_cnt_d = ones_cnt;

    case (state_q)
      IDLE: begin
        s_ready_d = 1'b0;
        busy_d    = 1'b0;
        if (start && !abort) begin
          if (int'(qber_sel) <= QBER_MAX) begin
            qber_d     = qber_sel;
            cnt_d      = '0;
            ones_cnt_d = '0;
            state_d    = LOAD;
            s_ready_d  = 1'b1;
            busy_d     = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (abort) begin
          state_d   = IDLE;
          s_ready_d = 1'b0;
          busy_d    = 1'b0;
        end else if (accept) begin
          llr_we_d   = 1'b1;
          llr_addr_d = cnt_q[ADDR_W-1:0];
          llr_data_d = lut_llr;
          llr_hard_d = lut_sign;
          ones_cnt_d = ones_cnt + {{ADDR_W{1'b0}}, s_bit};
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            done_d    = 1'b1;
            state_d   = IDLE;
            s_ready_d = 1'b0;
            busy_d    = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; async reset returns everything to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      qber_q   <= '0;
      s_ready  <= 1'b0;
      llr_we   <= 1'b0;
      llr_addr <= '0;
      llr_data <= '0;
      llr_hard <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      ones_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qber_q   <= qber_d;
      s_ready  <= s_ready_d;
      llr_we   <= llr_we_d;
      llr_addr <= llr_addr_d;
      llr_data <= llr_data_d;
      llr_hard <= llr_hard_d;
      busy     <= busy_d;
      done     <= done_d;
      cfg_err  <= cfg_err_d;
      ones_cnt <= ones_cnt_d;
    end
  end

endmodule

// File: tb/tb_llr_channel_loader.sv
// Directed bench for llr_channel_loader with an 8-bit frame.
module tb_llr_channel_loader;

  localparam int N_BITS = 8;
  localparam int ADDR_W = 3;
  localparam int LLR_W  = 15;

  localparam logic [14:0] Q0_P  = 15'h1261, Q0_N  = 15'h6D9F;
  localparam logic [14:0] Q10_P = 15'h085D;
  localparam logic [14:0] Q3_N  = 15'h734A;
  localparam logic [14:0] Q2_P  = 15'h0DE8, Q2_N  = 15'h7218;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort, s_valid, s_bit;
  logic [3:0]        qber_sel;
  logic              s_ready, llr_we, llr_hard, busy, done, cfg_err;
  logic [ADDR_W-1:0] llr_addr;
  logic [LLR_W-1:0]  llr_data;
  logic [ADDR_W:0]   ones_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  llr_channel_loader #(.N_BITS(N_BITS), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .qber_sel (qber_sel),
    .abort    (abort),
    .s_valid  (s_valid),
    .s_bit    (s_bit),
    .s_ready  (s_ready),
    .llr_we   (llr_we),
    .llr_addr (llr_addr),
    .llr_data (llr_data),
    .llr_hard (llr_hard),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .ones_cnt (ones_cnt)
  );

  always #5 clk = ~clk;

  // Independent tally of writes and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (llr_we === 1'b1) wr_cnt++;
    if (done === 1'b1)   done_cnt++;
  end

  typedef struct {
    logic        st;
    logic [3:0]  q;
    logic        ab;
    logic        v;
    logic        b;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs[10];

  // {we, addr, data, hard, done, ready, busy, cfg_err, ones}
  function automatic logic [27:0] pk(input logic we, input logic [2:0] a,
                                     input logic [14:0] d, input logic h,
                                     input logic dn, input logic rdy,
                                     input logic bsy, input logic ce,
                                     input logic [3:0] ones);
    return {we, a, d, h, dn, rdy, bsy, ce, ones};
  endfunction

  function automatic logic [27:0] outs();
    return {llr_we, llr_addr, llr_data, llr_hard, done, s_ready, busy, cfg_err, ones_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [3:0] q, input logic ab,
                       input logic v, input logic b);
    start = st; qber_sel = q; abort = ab; s_valid = v; s_bit = b;
  endtask

  int w0;
  int d0;

  initial begin
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #22;
    check("reset_outputs", {4'b0, outs()}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("idle_after_reset", {4'b0, outs()}, 32'h0);

    // ---- Frame 1: qber 0, back-to-back bits 0,1,0,0,1,1,0,1 ----
    vecs[0] = '{1, 4'd0, 0, 0, 0, pk(0, 0, 15'h0, 0, 0, 1, 1, 0, 0)};
    vecs[1] = '{0, 4'd0, 0, 1, 0, pk(1, 0, Q0_P, 0, 0, 1, 1, 0, 0)};
    vecs[2] = '{0, 4'd0, 0, 1, 1, pk(1, 1, Q0_N, 1, 0, 1, 1, 0, 1)};
    vecs[3] = '{0, 4'd0, 0, 1, 0, pk(1, 2, Q0_P, 0, 0, 1, 1, 0, 1)};
    vecs[4] = '{0, 4'd0, 0, 1, 0, pk(1, 3, Q0_P, 0, 0, 1, 1, 0, 1)};
    vecs[5] = '{0, 4'd0, 0, 1, 1, pk(1, 4, Q0_N, 1, 0, 1, 1, 0, 2)};
    vecs[6] = '{0, 4'd0, 0, 1, 1, pk(1, 5, Q0_N, 1, 0, 1, 1, 0, 3)};
    vecs[7] = '{0, 4'd0, 0, 1, 0, pk(1, 6, Q0_P, 0, 0, 1, 1, 0, 3)};
    vecs[8] = '{0, 4'd0, 0, 1, 1, pk(1, 7, Q0_N, 1, 1, 0, 0, 0, 4)};
    vecs[9] = '{0, 4'd0, 0, 1, 1, pk(0, 7, Q0_N, 1, 0, 0, 0, 0, 4)};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].st, vecs[i].q, vecs[i].ab, vecs[i].v, vecs[i].b);
      step();
      check($sformatf("f1_vec%0d", i), {4'b0, outs()}, {4'b0, vecs[i].exp});
    end
    drive(0, 0, 0, 0, 0);
    step();

    // ---- Frame 2: qber 10, all zeros, s_valid every other cycle ----
    w0 = wr_cnt;
    drive(1, 4'd10, 0, 0, 0);
    step();
    start = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid = (i % 2 == 0);
      step();
      check($sformatf("f2_we%0d", i), {31'b0, llr_we}, {31'b0, (i % 2 == 0)});
      check($sformatf("f2_done%0d", i), {31'b0, done}, {31'b0, (i == 14)});
      if (i % 2 == 0) begin
        check($sformatf("f2_addr%0d", i), {29'b0, llr_addr}, 32'(i / 2));
        check($sformatf("f2_data%0d", i), {17'b0, llr_data}, {17'b0, Q10_P});
      end
    end
    check("f2_write_count", 32'(wr_cnt - w0), 32'd8);
    check("f2_ones", {28'b0, ones_cnt}, 32'd0);
    check("f2_ready_low", {31'b0, s_ready}, 32'd0);
    s_valid = 0;
    step();

    // ---- Illegal QBER code, then a legal start ----
    w0 = wr_cnt;
    drive(1, 4'd11, 0, 1, 1);
    step();
    check("cfg_err_pulse", {31'b0, cfg_err}, 32'd1);
    check("cfg_ready_low", {31'b0, s_ready}, 32'd0);
    check("cfg_ones_hold", {28'b0, ones_cnt}, 32'd0);
    drive(0, 4'd0, 0, 1, 1);
    step();
    check("cfg_err_one_cycle", {31'b0, cfg_err}, 32'd0);
    check("cfg_no_writes", 32'(wr_cnt - w0), 32'd0);
    drive(1, 4'd3, 0, 0, 0);
    step();
    check("q3_ready", {31'b0, s_ready}, 32'd1);
    drive(0, 4'd0, 0, 1, 1);
    step();
    check("q3_first_write", {3'b0, llr_we, llr_addr, llr_data, 10'b0},
          {3'b0, 1'b1, 3'd0, Q3_N, 10'b0});
    drive(0, 4'd0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();

    // ---- Abort coincident with a valid bit after 3 accepts ----
    w0 = wr_cnt; d0 = done_cnt;
    drive(1, 4'd0, 0, 0, 0);
    step();
    drive(0, 4'd0, 0, 1, 1); step();
    drive(0, 4'd0, 0, 1, 0); step();
    drive(0, 4'd0, 0, 1, 1); step();
    check("ab_third_write", {28'b0, llr_we, llr_addr}, {28'b0, 1'b1, 3'd2});
    drive(0, 4'd0, 1, 1, 1);
    step();
    check("ab_next_cycle", {4'b0, outs()}, {4'b0, pk(0, 2, Q0_N, 1, 0, 0, 0, 0, 2)});
    drive(0, 0, 0, 1, 1);
    step();
    check("ab_write_count", 32'(wr_cnt - w0), 32'd3);
    check("ab_no_done", 32'(done_cnt - d0), 32'd0);
    check("ab_stays_idle", {30'b0, s_ready, llr_we}, 32'd0);
    drive(1, 4'd0, 0, 0, 0);
    step();
    check("ab_restart_ones_clr", {28'b0, ones_cnt}, 32'd0);
    drive(0, 4'd0, 0, 1, 0);
    step();
    check("ab_restart_addr0", {3'b0, llr_we, llr_addr, llr_data, 10'b0},
          {3'b0, 1'b1, 3'd0, Q0_P, 10'b0});
    drive(0, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();

    // ---- start pulsed during a qber 2 frame is ignored ----
    drive(1, 4'd2, 0, 0, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(i == 3, (i == 3) ? 4'd5 : 4'd2, 0, 1, (i % 2 == 1));
      step();
      check($sformatf("st_data%0d", i), {17'b0, llr_data}, {17'b0, (i % 2 == 1) ? Q2_N : Q2_P});
      check($sformatf("st_addr%0d", i), {28'b0, llr_we, llr_addr}, {28'b0, 1'b1, 3'(i)});
      check($sformatf("st_cfg%0d", i), {30'b0, cfg_err, done}, {30'b0, 1'b0, (i == 7)});
    end
    check("st_ones", {28'b0, ones_cnt}, 32'd4);
    drive(0, 0, 0, 0, 0);
    step();

    // ---- Async reset after 4 accepts ----
    d0 = done_cnt;
    drive(1, 4'd0, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'd0, 0, 1, 1);
      step();
    end
    check("rst_pre_ones", {28'b0, ones_cnt}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_zero", {4'b0, outs()}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) step();
    check("rst_idle_ready", {31'b0, s_ready}, 32'd0);
    check("rst_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_outputs_zero", {4'b0, outs()}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/llr_channel_loader.md
Name: llr_channel_loader

Overview:
- Downstream consumer of the channel-LLR lookup table.
- Accepts one sifted-key frame as a bit stream under a valid/ready handshake, latches the frame's QBER index, and converts each bit into its channel LLR L(Pi) (Q5.10, 15-bit two's complement).
- Writes each LLR, plus its hard-decision bit, sequentially into the decoder's variable-node LLR memory, then signals frame completion.
- Sits between the key-sifting front end and the LDPC min-sum decoder core.

Parameters:
- N_BITS, 1024, codeword length (bits per frame); minimum 2.
- ADDR_W, 10, LLR memory address width; must satisfy 2^ADDR_W >= N_BITS.
- LLR_W, 15, LLR data width (Q5.10); fixed to the table format.
- QBER_MAX, 10, highest legal qber_sel code (0..10 => 0.01..0.11).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame start request; honoured only in IDLE.
- qber_sel  in  4  QBER index; sampled on accepted start.
- abort  in  1  synchronous abort; returns to IDLE with no done.
- s_valid  in  1  key bit valid.
- s_bit  in  1  key bit xi.
- s_ready  out  1  loader can accept a bit.
- llr_we  out  1  LLR memory write enable.
- llr_addr  out  ADDR_W  write address (bit index).
- llr_data  out  LLR_W  L(Pi) for the bit.
- llr_hard  out  1  hard decision (= xi, the LLR sign).
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse, coincident with the frame's final llr_we.
- cfg_err  out  1  one-cycle pulse on start with qber_sel > QBER_MAX.
- ones_cnt  out  ADDR_W+1  number of 1 bits in the last/current frame.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE.
  - s_ready, llr_we, busy, done, cfg_err = 0.
  - llr_addr, llr_data, llr_hard = 0.
  - ones_cnt = 0; latched qber = 0; bit counter = 0.
- All outputs are registered.
- IDLE:
  - s_ready = 0.
  - start with qber_sel <= QBER_MAX: latch qber_sel, clear bit counter and ones_cnt, go to LOAD. s_ready and busy are 1 the next cycle.
  - start with qber_sel > QBER_MAX: cfg_err = 1 for exactly one cycle, stay in IDLE, ones_cnt unchanged.
- LOAD:
  - s_ready = 1 while fewer than N_BITS bits have been accepted.
  - A bit is accepted on a cycle with s_valid & s_ready.
  - For a bit accepted at cycle t, the cycle t+1 outputs are:
    - llr_we = 1.
    - llr_addr = index (0..N_BITS-1).
    - llr_data = LUT(s_bit, latched qber).
    - llr_hard = s_bit.
  - Latency is 1 cycle. Back-to-back acceptance sustains one write per cycle.
  - ones_cnt increments with each accepted 1, registered with the write.
  - On acceptance of bit N_BITS-1: s_ready drops the next cycle. That cycle carries the final llr_we and done = 1. State returns to IDLE, busy = 0.
  - s_valid low: no write (llr_we = 0). llr_addr/llr_data hold their last values.
  - start during LOAD is ignored: the latched qber is not changed and cfg_err is not raised.
- abort:
  - Takes priority over start and acceptance in the same cycle.
  - Any bit presented in the abort cycle is not accepted and not written.
  - Next cycle: IDLE, s_ready = 0, busy = 0, done = 0.
  - A write already registered from the previous cycle still completes.
  - ones_cnt holds its partial value.
- Async reset mid-frame: immediate return to reset values. No done, no further writes.
- After done: llr_addr/llr_data/llr_hard hold; ones_cnt holds until the next accepted start.
- LLR values (Q5.10, 15-bit hex), xi=0 for qber_sel 0..10:
  - 1261, 0F91, 0DE8, 0CB6, 0BC7, 0B02, 0A59, 09C5, 0941, 08CA, 085D.
  - xi=1 gives the 15-bit two's-complement negation of the xi=0 value (e.g. 6D9F for qber_sel 0, 77A3 for qber_sel 10).
- The bit counter never wraps: N_BITS is the terminal count, and the counter is cleared only by start or reset.

Decomposition:
- Shared ldpc package:
  - LLR_W = 15, LLR_FRAC = 10.
  - QBER_MAX = 10, QBER_SEL_W = 4.
  - State encoding: IDLE, LOAD.
- Sub-module: instantiate the existing combinational table Lookup_table_eq6 (inputs xi, qber_sel; outputs L_Pi, sign). It is fed s_bit and the latched qber, and its output is registered here. No duplicate table.

Test Plan:
- N_BITS=8, start with qber_sel=0, bits 0,1,0,0,1,1,0,1 with s_valid held high -> 8 consecutive writes at addr 0..7:
  - llr_data 1261, 6D9F, 1261, 1261, 6D9F, 6D9F, 1261, 6D9F.
  - done coincides with the addr 7 write; ones_cnt = 4; s_ready low after the 8th accept.
- qber_sel=10, all-zero frame with s_valid toggling every other cycle -> writes only on accept+1, all 085D.
  - No writes in gap cycles; done after 8 writes; ones_cnt = 0.
- start with qber_sel=11 -> cfg_err pulses 1 cycle, s_ready stays 0, no writes. A following start with qber_sel=3 and a bit of 1 -> first write 734A.
- Abort after 3 accepted bits, with abort and s_valid coincident -> exactly 3 writes (addr 0..2), no done, IDLE next cycle. A new start restarts at addr 0.
- start (qber_sel=5) pulsed during LOAD of a qber_sel=2 frame -> all LLRs remain 0DE8/7218, no restart, cfg_err = 0.
- rst_n asserted mid-frame (after 4 accepts) -> all outputs 0 immediately (async). After release, IDLE with s_ready = 0 and no spurious done.
